// File: rtl/slow_clk_pwm.sv
// slow_clk_pwm: synchronises a divided clock into one-cycle ticks that step a PWM whose duty
// is taken from a handshaked shadow register and applied only at period boundaries.
module slow_clk_pwm #(
  parameter int W = 8,
  parameter int PERIOD = 10,
  parameter logic [W-1:0] DUTY_RST = '0
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         slow_clk,
  input  logic [W-1:0] duty_in,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic         tick,
  output logic         period_start,
  output logic         pwm_out
);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);
  logic sync1, sync2, prev, pending, wrap, take;
  logic [W-1:0] cnt, duty_act, shadow;
  assign wrap = tick && cnt == LAST;
  assign take = duty_valid && !pending;
  assign duty_ready = !pending;
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev <= 1'b0;
      tick <= 1'b0;
      period_start <= 1'b0;
      pwm_out <= 1'b0;
      cnt <= '0;
      duty_act <= DUTY_RST;
      shadow <= '0;
      pending <= 1'b0;
    end else begin
      sync1 <= slow_clk;
      sync2 <= sync1;
      prev <= sync2;
      tick <= sync2 & ~prev;
      period_start <= wrap;
      pwm_out <= cnt < duty_act;
      if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap && pending) duty_act <= shadow;
      if (take) shadow <= duty_in;
      // take only fires while empty, so it never collides with a consuming wrap
      pending <= take | (pending & ~wrap);
    end
endmodule
